// File: rtl/prog_clock_divider_pkg.sv
// ------------------------------------------------------------------
// | clk_div_pkg : shared mode encoding and sizing helpers           |
// | Revision    : 1.0                                               |
// ------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_TICK   = 1'b1
    } ch_mode_e;

    localparam int CNT_W_DEFAULT = 25;

    // Channel-select width never collapses to zero for a single channel
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_clock_divider_if.sv
// ------------------------------------------------------------------
// | prog_clock_divider_if : control/load bus and per-channel outputs |
// | Revision              : 1.0                                      |
// ------------------------------------------------------------------
`default_nettype none

interface prog_clock_divider_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEFAULT
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] mode;
    logic              sync;
    logic              div_load;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_value;
    logic [NUM_CH-1:0] slow_clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (
        output en, mode, sync, div_load, div_ch, div_value,
        input  slow_clk, tick, pending
    );

    modport slave (
        input  en, mode, sync, div_load, div_ch, div_value,
        output slow_clk, tick, pending
    );

endinterface

`default_nettype wire

// File: rtl/prog_clock_divider_channel.sv
// ------------------------------------------------------------------
// | div_channel : one divider with active/shadow divisor and outputs |
// | Revision    : 1.0                                                |
// ------------------------------------------------------------------
`default_nettype none

module div_channel
    import clk_div_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en_i,
    input  wire logic             mode_i,
    input  wire logic             sync_i,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_value_i,
    output logic                  slow_clk_o,
    output logic                  tick_o,
    output logic                  pending_o
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    ch_mode_e         w_mode;
    logic             w_term;

    assign w_mode = ch_mode_e'(mode_i);
    assign w_term = (cnt_q >= act_q);

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        slow_d = slow_q;
        tick_d = 1'b0;
        if (sync_i) begin
            cnt_d  = '0;
            slow_d = 1'b0;
            if (load_i) begin
                act_d  = load_value_i;
                shd_d  = load_value_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
        end else begin
            if (en_i) begin
                if (w_term) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    slow_d = (w_mode == MODE_TOGGLE) ? ~slow_q : 1'b0;
                    if (pend_q) begin
                        act_d  = shd_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_mode == MODE_TICK) slow_d = 1'b0;
                end
            end else begin
                if (w_mode == MODE_TICK) slow_d = 1'b0;
                // Committing while paused: clamp a held count above the new divisor
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                    if (cnt_q > shd_q) cnt_d = shd_q;
                end
            end
            // A load racing a commit lands in the shadow and stays pending
            if (load_i) begin
                shd_d  = load_value_i;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= c_default_div;
            shd_q  <= c_default_div;
            pend_q <= 1'b0;
            slow_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            slow_q <= slow_d;
            tick_q <= tick_d;
        end
    end

    assign slow_clk_o = slow_q;
    assign tick_o     = tick_q;
    assign pending_o  = pend_q;

endmodule

`default_nettype wire

// File: rtl/prog_clock_divider.sv
// ------------------------------------------------------------------
// | prog_clock_divider : multi-channel programmable divider / ticks  |
// | Revision           : 1.0                                         |
// ------------------------------------------------------------------
`default_nettype none

module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input wire logic              clk,
    input wire logic              rst,
    prog_clock_divider_if.slave   bus_io
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_slow;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_pend;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic w_load;

            // Full-width compare, so selects at or beyond NUM_CH hit no channel
            assign w_load = bus_io.div_load && (bus_io.div_ch == CH_W'(g));

            div_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .en_i         (bus_io.en[g]),
                .mode_i       (bus_io.mode[g]),
                .sync_i       (bus_io.sync),
                .load_i       (w_load),
                .load_value_i (bus_io.div_value),
                .slow_clk_o   (w_slow[g]),
                .tick_o       (w_tick[g]),
                .pending_o    (w_pend[g])
            );
        end
    endgenerate

    assign bus_io.slow_clk = w_slow;
    assign bus_io.tick     = w_tick;
    assign bus_io.pending  = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
// ------------------------------------------------------------------
// | tb_prog_clock_divider : scoreboard bench for prog_clock_divider  |
// | Revision              : 1.0                                      |
// ------------------------------------------------------------------
`default_nettype none

module tb_prog_clock_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        int   ch;
        int   cyc;
        logic slow;
    } exp_t;

    exp_t sbq[$];

    prog_clock_divider_if #(.NUM_CH(3), .CNT_W(8)) bus ();

    prog_clock_divider #(
        .NUM_CH      (3),
        .CNT_W       (8),
        .DEFAULT_DIV (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int ch, input int c, input logic s);
        exp_t e;
        e.ch = ch; e.cyc = c; e.slow = s;
        sbq.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every tick on ch0/ch1 must match a queued expectation
    always @(negedge clk) begin : mon
        int k;
        for (int ch = 0; ch < 2; ch++) begin
            k = -1;
            foreach (sbq[i])
                if (k < 0 && sbq[i].ch == ch && sbq[i].cyc == cyc) k = i;
            if (bus.tick[ch] === 1'b1) begin
                n_checks++;
                if (k < 0)
                    $display("FAIL unexpected_tick ch%0d cyc %0d: got tick=1, required tick=0", ch, cyc);
                else if (bus.slow_clk[ch] !== sbq[k].slow)
                    $display("FAIL slow_at_tick ch%0d cyc %0d: got %b, required %b",
                             ch, cyc, bus.slow_clk[ch], sbq[k].slow);
                else
                    n_pass++;
                if (k >= 0) sbq.delete(k);
            end else if (k >= 0) begin
                n_checks++;
                $display("FAIL missing_tick ch%0d cyc %0d: got tick=%b, required tick=1",
                         ch, cyc, bus.tick[ch]);
                sbq.delete(k);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no finish by 20000, required finish");
        $fatal(1);
    end

    initial begin
        bus.en = 3'b000; bus.mode = 3'b000; bus.sync = 1'b0;
        bus.div_load = 1'b0; bus.div_ch = 2'd0; bus.div_value = 8'd0;

        // Reset state
        goto(2);
        check("reset_slow", 32'(bus.slow_clk), 32'h0);
        check("reset_tick", 32'(bus.tick), 32'h0);
        check("reset_pending", 32'(bus.pending), 32'h0);

        // Toggle mode, D=3: ticks every 4 clks, slow_clk toggles on each
        rst = 1'b0; bus.en = 3'b011;
        for (int k = 1; k <= 4; k++) begin
            push(0, 2 + 4 * k, logic'(k % 2));
            push(1, 2 + 4 * k, logic'(k % 2));
        end

        // ch0 gets D=9 while its count is 1; current period still ends at 22
        goto(19);
        bus.div_load = 1'b1; bus.div_ch = 2'd0; bus.div_value = 8'd9;
        push(0, 22, 1'b1); push(0, 32, 1'b0); push(0, 42, 1'b1);
        goto(20);
        check("pending_ch0_loaded", 32'(bus.pending), 32'h1);
        bus.div_ch = 2'd1; bus.div_value = 8'd0; bus.mode = 3'b010;
        for (int c = 22; c <= 60; c++) push(1, c, 1'b0);
        goto(21);
        bus.div_load = 1'b0;
        check("pending_both", 32'(bus.pending), 32'h3);
        goto(22);
        check("pending_committed", 32'(bus.pending), 32'h0);
        goto(30);
        check("ch1_tick_mode_slow", 32'(bus.slow_clk[1]), 32'h0);

        // ch0 paused for 5 clks at count 2
        goto(44);
        bus.en = 3'b010;
        push(0, 57, 1'b0);
        goto(47);
        check("pause_slow_hold", 32'(bus.slow_clk[0]), 32'h1);
        goto(49);
        bus.en = 3'b011;

        // sync plus same-cycle load of ch0 D=5
        goto(60);
        bus.sync = 1'b1; bus.div_load = 1'b1; bus.div_ch = 2'd0; bus.div_value = 8'd5;
        push(0, 67, 1'b1); push(0, 73, 1'b0);
        for (int c = 62; c <= 76; c++) push(1, c, 1'b0);
        goto(61);
        bus.sync = 1'b0; bus.div_load = 1'b0;
        check("sync_slow", 32'(bus.slow_clk), 32'h0);
        check("sync_tick", 32'(bus.tick), 32'h0);
        check("sync_pending", 32'(bus.pending), 32'h0);

        // Pending load then reset mid-period, then an out-of-range load
        goto(75);
        bus.div_load = 1'b1; bus.div_ch = 2'd0; bus.div_value = 8'd2;
        goto(76);
        check("pending_before_rst", 32'(bus.pending), 32'h1);
        bus.div_load = 1'b0; rst = 1'b1;
        goto(77);
        check("rst_slow", 32'(bus.slow_clk), 32'h0);
        check("rst_tick", 32'(bus.tick), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        rst = 1'b0; bus.mode = 3'b000; bus.en = 3'b011;
        bus.div_load = 1'b1; bus.div_ch = 2'd3; bus.div_value = 8'd1;
        push(0, 81, 1'b1); push(1, 81, 1'b1);
        push(0, 85, 1'b0); push(1, 85, 1'b0);
        goto(78);
        bus.div_load = 1'b0;
        check("oor_load_pending", 32'(bus.pending), 32'h0);

        goto(88);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
